// File: rtl/ka_overlap_pkg.sv
// Shared sizing helpers and types for the overlap accumulator.
// Legal NSEG range is 2..16; every width below is derived from the generics.
package ka_overlap_pkg;

  typedef enum logic {
    OUT_EMPTY = 1'b0,
    OUT_FULL  = 1'b1
  } out_state_e;

  function automatic int calc_out_w(input int nseg, input int shift, input int seg_w);
    return (nseg - 1) * shift + seg_w;
  endfunction

  function automatic int calc_idx_w(input int nseg);
    return (nseg < 2) ? 1 : $clog2(nseg);
  endfunction

endpackage

// File: rtl/overlap_shift_xor.sv
// Combinational GF(2) overlap: XORs a segment into the accumulator at idx*SHIFT.
module overlap_shift_xor
  import ka_overlap_pkg::*;
#(
  parameter int SEG_W = 9,
  parameter int SHIFT = 5,
  parameter int NSEG  = 3,
  parameter int OUT_W = calc_out_w(NSEG, SHIFT, SEG_W),
  parameter int IDX_W = calc_idx_w(NSEG)
) (
  input  logic [OUT_W-1:0] acc,
  input  logic [SEG_W-1:0] seg,
  input  logic [IDX_W-1:0] idx,
  output logic [OUT_W-1:0] result
);

  logic [OUT_W-1:0] seg_ext;
  logic [OUT_W-1:0] shifted;

  assign seg_ext = OUT_W'(seg);

  // One constant shifter per legal index keeps the barrel shift shallow.
  always_comb begin
    shifted = '0;
    for (int k = 0; k < NSEG; k++) begin
      if (idx == IDX_W'(k)) begin
        shifted = seg_ext << (k * SHIFT);
      end
    end
  end

  assign result = acc ^ shifted;

endmodule

// File: rtl/overlap_accum_seq.sv
// Streaming Karatsuba overlap combiner: accumulates NSEG shifted segments per
// frame and hands the combined product to a back-pressured output register.
module overlap_accum_seq
  import ka_overlap_pkg::*;
#(
  parameter int SEG_W = 9,
  parameter int SHIFT = 5,
  parameter int NSEG  = 3,
  localparam int OUT_W = calc_out_w(NSEG, SHIFT, SEG_W),
  localparam int IDX_W = calc_idx_w(NSEG)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [SEG_W-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             err
);

  logic [IDX_W-1:0] idx;
  logic [OUT_W-1:0] acc;
  logic [OUT_W-1:0] acc_base;
  logic [OUT_W-1:0] acc_next;
  out_state_e       out_state;
  logic             idx_last;
  logic             closing_possible;
  logic             accept;
  logic             closing;

  assign out_valid        = (out_state == OUT_FULL);
  assign idx_last         = (idx == IDX_W'(NSEG - 1));
  assign closing_possible = idx_last || in_last;
  // Only a beat that would overwrite a stalled result is held off.
  assign in_ready         = !(closing_possible && out_valid && !out_ready);
  assign accept           = in_valid && in_ready;
  assign closing          = accept && closing_possible;

  // First beat of a frame overwrites rather than accumulates; no clear cycle.
  assign acc_base = (idx == '0) ? '0 : acc;

  overlap_shift_xor #(
    .SEG_W(SEG_W),
    .SHIFT(SHIFT),
    .NSEG (NSEG),
    .OUT_W(OUT_W),
    .IDX_W(IDX_W)
  ) u_shift_xor (
    .acc   (acc_base),
    .seg   (in_data),
    .idx   (idx),
    .result(acc_next)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx       <= '0;
      acc       <= '0;
      out_data  <= '0;
      out_state <= OUT_EMPTY;
      err       <= 1'b0;
    end else begin
      if (accept) begin
        acc <= acc_next;
        idx <= closing ? '0 : idx + IDX_W'(1);
      end
      // Early in_last or a missing in_last on the final slot both flag err.
      if (closing && (idx_last != in_last)) begin
        err <= 1'b1;
      end
      if (closing) begin
        out_data  <= acc_next;
        out_state <= OUT_FULL;
      end else if (out_state == OUT_FULL && out_ready) begin
        out_state <= OUT_EMPTY;
      end
    end
  end

endmodule

// File: tb/tb_overlap_accum_seq.sv
// Self-checking bench for overlap_accum_seq at default and swept parameters.
module tb_overlap_accum_seq;

  logic        clk;
  logic        rst_n;

  logic        d_in_valid, d_in_ready, d_in_last, d_out_valid, d_out_ready, d_err;
  logic [8:0]  d_in_data;
  logic [18:0] d_out_data;

  logic        w_in_valid, w_in_ready, w_in_last, w_out_valid, w_out_ready, w_err;
  logic [15:0] w_in_data;
  logic [39:0] w_out_data;

  int n_checks = 0;
  int n_fail   = 0;

  overlap_accum_seq dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (d_in_valid),
    .in_ready (d_in_ready),
    .in_data  (d_in_data),
    .in_last  (d_in_last),
    .out_valid(d_out_valid),
    .out_ready(d_out_ready),
    .out_data (d_out_data),
    .err      (d_err)
  );

  overlap_accum_seq #(.SEG_W(16), .SHIFT(8), .NSEG(4)) dut4 (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (w_in_valid),
    .in_ready (w_in_ready),
    .in_data  (w_in_data),
    .in_last  (w_in_last),
    .out_valid(w_out_valid),
    .out_ready(w_out_ready),
    .out_data (w_out_data),
    .err      (w_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: GF(2) sum of each segment shifted by its position.
  function automatic logic [63:0] combine(input logic [15:0] segs[$], input int shift);
    logic [63:0] r;
    r = '0;
    foreach (segs[k]) r = r ^ (64'(segs[k]) << (k * shift));
    return r;
  endfunction

  task automatic drive(input logic v, input logic [8:0] d, input logic l, input logic r);
    d_in_valid  = v;
    d_in_data   = d;
    d_in_last   = l;
    d_out_ready = r;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(1'b0, '0, 1'b0, 1'b0);
    w_in_valid = 1'b0; w_in_data = '0; w_in_last = 1'b0; w_out_ready = 1'b0;
    @(negedge clk);
    n_checks++; if (d_in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_in_ready: got %b expected 1", d_in_ready); end
    n_checks++; if (d_out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_out_valid: got %b expected 0", d_out_valid); end
    n_checks++; if (d_out_data !== 19'h0) begin n_fail++; $display("[TB] FAIL reset_out_data: got %h expected 0", d_out_data); end
    n_checks++; if (d_err !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_err: got %b expected 0", d_err); end
    n_checks++; if (w_out_valid !== 1'b0 || w_out_data !== 40'h0 || w_in_ready !== 1'b1) begin
      n_fail++; $display("[TB] FAIL reset_wide: got valid=%b data=%h ready=%b expected 0/0/1", w_out_valid, w_out_data, w_in_ready);
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_single_frame();
    logic [15:0] segs[$];
    logic [63:0] exp;
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 9'h1FF, k == 2, 1'b1);
      n_checks++; if (d_in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL single_in_ready beat %0d: got %b expected 1", k, d_in_ready); end
      segs.push_back(16'h1FF);
      step();
    end
    drive(1'b0, '0, 1'b0, 1'b1);
    exp = combine(segs, 5);
    n_checks++; if (d_out_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL single_out_valid: got %b expected 1", d_out_valid); end
    n_checks++; if (d_out_data !== exp[18:0]) begin n_fail++; $display("[TB] FAIL single_out_data: got %h expected %h", d_out_data, exp[18:0]); end
    n_checks++; if (d_err !== 1'b0) begin n_fail++; $display("[TB] FAIL single_err: got %b expected 0", d_err); end
    step();
    n_checks++; if (d_out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL single_drain: got %b expected 0", d_out_valid); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] segs[$];
    logic [63:0] exp;
    logic [8:0]  d;
    for (int k = 0; k < 6; k++) begin
      d = (k < 3) ? 9'h001 : 9'h1FF;
      drive(1'b1, d, (k % 3) == 2, 1'b1);
      segs.push_back(16'(d));
      step();
      if ((k % 3) == 2) begin
        exp = combine(segs, 5);
        segs.delete();
        n_checks++; if (d_out_valid !== 1'b1 || d_out_data !== exp[18:0]) begin
          n_fail++; $display("[TB] FAIL b2b_frame_%0d: got valid=%b data=%h expected valid=1 data=%h", k / 3, d_out_valid, d_out_data, exp[18:0]);
        end
      end
    end
    drive(1'b0, '0, 1'b0, 1'b1);
    step();
  endtask

  task automatic test_stall();
    logic [15:0] s1[$], s2[$];
    logic [63:0] e1, e2;
    logic [8:0]  d;
    for (int k = 0; k < 3; k++) begin
      d = 9'($urandom);
      drive(1'b1, d, k == 2, 1'b1);
      s1.push_back(16'(d));
      step();
    end
    e1 = combine(s1, 5);
    for (int k = 0; k < 2; k++) begin
      d = 9'($urandom);
      drive(1'b1, d, 1'b0, 1'b0);
      n_checks++; if (d_in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL stall_nonclosing_ready beat %0d: got %b expected 1", k, d_in_ready); end
      s2.push_back(16'(d));
      step();
    end
    d = 9'($urandom);
    drive(1'b1, d, 1'b1, 1'b0);
    s2.push_back(16'(d));
    e2 = combine(s2, 5);
    n_checks++; if (d_in_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL stall_closing_ready: got %b expected 0", d_in_ready); end
    step();
    n_checks++; if (d_in_ready !== 1'b0 || d_out_valid !== 1'b1 || d_out_data !== e1[18:0]) begin
      n_fail++; $display("[TB] FAIL stall_hold: got ready=%b valid=%b data=%h expected 0/1/%h", d_in_ready, d_out_valid, d_out_data, e1[18:0]);
    end
    d_out_ready = 1'b1;
    #1;
    n_checks++; if (d_in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL stall_release_ready: got %b expected 1", d_in_ready); end
    step();
    drive(1'b0, '0, 1'b0, 1'b1);
    n_checks++; if (d_out_valid !== 1'b1 || d_out_data !== e2[18:0]) begin
      n_fail++; $display("[TB] FAIL stall_frame2: got valid=%b data=%h expected 1/%h", d_out_valid, d_out_data, e2[18:0]);
    end
    step();
  endtask

  task automatic test_early_last();
    logic [15:0] segs[$];
    logic [63:0] exp;
    logic [8:0]  d;
    for (int k = 0; k < 2; k++) begin
      drive(1'b1, 9'h001, k == 1, 1'b1);
      segs.push_back(16'h001);
      step();
    end
    exp = combine(segs, 5);
    n_checks++; if (d_out_data !== exp[18:0] || d_err !== 1'b1) begin
      n_fail++; $display("[TB] FAIL early_last: got data=%h err=%b expected %h/1", d_out_data, d_err, exp[18:0]);
    end
    segs.delete();
    for (int k = 0; k < 3; k++) begin
      d = 9'($urandom);
      drive(1'b1, d, k == 2, 1'b1);
      segs.push_back(16'(d));
      step();
    end
    drive(1'b0, '0, 1'b0, 1'b1);
    exp = combine(segs, 5);
    n_checks++; if (d_out_data !== exp[18:0] || d_err !== 1'b1) begin
      n_fail++; $display("[TB] FAIL err_sticky: got data=%h err=%b expected %h/1", d_out_data, d_err, exp[18:0]);
    end
    step();
  endtask

  task automatic test_reset_mid_frame();
    logic [15:0] segs[$];
    logic [63:0] exp;
    for (int k = 0; k < 2; k++) begin
      drive(1'b1, 9'($urandom), 1'b0, 1'b1);
      step();
    end
    drive(1'b0, '0, 1'b0, 1'b1);
    rst_n = 1'b0;
    #1;
    n_checks++; if (d_out_valid !== 1'b0 || d_err !== 1'b0 || d_out_data !== 19'h0) begin
      n_fail++; $display("[TB] FAIL midreset_state: got valid=%b err=%b data=%h expected 0/0/0", d_out_valid, d_err, d_out_data);
    end
    @(negedge clk);
    rst_n = 1'b1;
    step();
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 9'h001, k == 2, 1'b1);
      segs.push_back(16'h001);
      step();
    end
    drive(1'b0, '0, 1'b0, 1'b1);
    exp = combine(segs, 5);
    n_checks++; if (d_out_valid !== 1'b1 || d_out_data !== exp[18:0] || d_err !== 1'b0) begin
      n_fail++; $display("[TB] FAIL midreset_clean: got valid=%b data=%h err=%b expected 1/%h/0", d_out_valid, d_out_data, d_err, exp[18:0]);
    end
    step();
  endtask

  // Randomised traffic against a frame-level scoreboard with sticky err.
  task automatic test_random();
    logic [15:0] segs[$];
    logic        held, err_m, v, l, r, closing_possible, exp_ready;
    logic [63:0] held_data;
    logic [8:0]  d;
    held = 1'b0; err_m = 1'b0; held_data = '0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      n_checks++; if (d_out_valid !== held || d_err !== err_m || (held && d_out_data !== held_data[18:0])) begin
        n_fail++; $display("[TB] FAIL random_out cyc %0d: got valid=%b err=%b data=%h expected %b/%b/%h", cyc, d_out_valid, d_err, d_out_data, held, err_m, held_data[18:0]);
      end
      v = ($urandom_range(0, 3) != 0);
      d = 9'($urandom);
      if (segs.size() == 2) l = ($urandom_range(0, 4) != 0);
      else l = ($urandom_range(0, 5) == 0);
      r = ($urandom_range(0, 2) != 0);
      drive(v, d, l, r);
      closing_possible = (segs.size() == 2) || l;
      exp_ready = !(closing_possible && held && !r);
      #1;
      n_checks++; if (d_in_ready !== exp_ready) begin
        n_fail++; $display("[TB] FAIL random_in_ready cyc %0d: got %b expected %b", cyc, d_in_ready, exp_ready);
      end
      if (v && exp_ready) segs.push_back(16'(d));
      if (v && exp_ready && closing_possible) begin
        if ((l && segs.size() < 3) || (segs.size() == 3 && !l)) err_m = 1'b1;
        held_data = combine(segs, 5);
        held = 1'b1;
        segs.delete();
      end else if (held && r) begin
        held = 1'b0;
      end
      step();
    end
    drive(1'b0, '0, 1'b0, 1'b1);
    step();
  endtask

  task automatic test_param_sweep();
    logic [15:0] segs[$];
    logic [63:0] exp;
    logic [15:0] d;
    for (int f = 0; f < 2; f++) begin
      segs.delete();
      for (int k = 0; k < 4; k++) begin
        d = (f == 0) ? 16'hFFFF : 16'($urandom);
        w_in_valid = 1'b1; w_in_data = d; w_out_ready = 1'b1;
        w_in_last = (f == 0) && (k == 3);
        segs.push_back(d);
        step();
      end
      w_in_valid = 1'b0; w_in_last = 1'b0;
      exp = combine(segs, 8);
      n_checks++; if (w_out_valid !== 1'b1 || w_out_data !== exp[39:0]) begin
        n_fail++; $display("[TB] FAIL sweep_frame_%0d: got valid=%b data=%h expected 1/%h", f, w_out_valid, w_out_data, exp[39:0]);
      end
      n_checks++; if (w_err !== (f == 1)) begin
        n_fail++; $display("[TB] FAIL sweep_err_%0d: got %b expected %b", f, w_err, (f == 1));
      end
      step();
    end
  endtask

  initial begin
    $display("[TB] overlap_accum_seq bench start");
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_stall();
    test_early_last();
    test_reset_mid_frame();
    test_random();
    test_param_sweep();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
